cache_line_adapter: RTL and testbench

//  Memory-side responder for the cache controller's line-miss/writeback protocol.
//  - Read: services a read-miss request by fetching one 256-bit line from word-wide main memory.
//  - Writeback: services a writeback request by storing one 256-bit line to main memory.
//  - Each transfer is 8 sequential 32-bit word accesses on the memory's second port.
//  - Sits between the cache controller and the dual-port RAM.

---
 rtl/cache_line_adapter.sv | 115 +++++++++++
 tb/tb_cache_line_adapter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_line_adapter.sv
// cache_line_adapter: memory-side responder that fetches or writes back one cache line as word accesses on RAM port 2
// Ports:
//   CLK, RESET_N (async, active-low), ADAPTERRESET (sync abort from cache)
//   READ_MISS/READWRITE_MISS_ADDR : line fetch request, CACHELINEIN/CACHELINEREADY : fetched line + pulse
//   MEMORYWRITE/WRITEBACK_ADDR/CACHELINEOUT : writeback request, CACHELINEWRITTEN : completion pulse
//   MEM_RDEN2/MEM_WE2/MEM_ADDR2/MEM_SIZE2/MEM_DIN2/MEM_DOUT2 : word-wide RAM port
module cache_line_adapter #(
    parameter int LINE_WORDS = 8,
    parameter int CNT_W      = $clog2(LINE_WORDS)
) (
    input  logic                     CLK,
    input  logic                     RESET_N,
    input  logic                     ADAPTERRESET,
    input  logic                     READ_MISS,
    input  logic [31:0]              READWRITE_MISS_ADDR,
    input  logic                     MEMORYWRITE,
    input  logic [31:0]              WRITEBACK_ADDR,
    input  logic [32*LINE_WORDS-1:0] CACHELINEOUT,
    output logic [32*LINE_WORDS-1:0] CACHELINEIN,
    output logic                     CACHELINEREADY,
    output logic                     CACHELINEWRITTEN,
    output logic                     MEM_RDEN2,
    output logic                     MEM_WE2,
    output logic [31:0]              MEM_ADDR2,
    output logic [1:0]               MEM_SIZE2,
    output logic [31:0]              MEM_DIN2,
    input  logic [31:0]              MEM_DOUT2
);
    typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_DRAIN, RD_DONE, WR_ISSUE, WR_DONE} state_t;
    state_t                  state, state_n;
    logic [CNT_W-1:0]        cnt, cnt_n, wi;
    logic [26:0]             base, base_n;
    logic [32*LINE_WORDS-1:0] wline, wline_n, line_in_n;
    logic                    last, rden_n, we_n, ready_n, written_n;
    logic [31:0]             addr_n, din_n;
    logic                    unused_lo;

    assign unused_lo = ^{READWRITE_MISS_ADDR[4:0], WRITEBACK_ADDR[4:0]};
    assign MEM_SIZE2 = 2'b10;
    assign last      = cnt == CNT_W'(LINE_WORDS - 1);
    // read data lags its request by one cycle, so each issue cycle stores the previous word
    assign wi        = (state == RD_DRAIN) ? '1 : cnt - CNT_W'(1);

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        base_n    = base;
        wline_n   = wline;
        line_in_n = CACHELINEIN;
        case (state)
            IDLE: begin
                if (MEMORYWRITE) begin
                    base_n  = WRITEBACK_ADDR[31:5];
                    wline_n = CACHELINEOUT;
                    state_n = WR_ISSUE;
                end else if (READ_MISS) begin
                    base_n  = READWRITE_MISS_ADDR[31:5];
                    state_n = RD_ISSUE;
                end
            end
            RD_ISSUE: begin
                cnt_n   = cnt + CNT_W'(1);
                state_n = last ? RD_DRAIN : RD_ISSUE;
            end
            RD_DRAIN: state_n = RD_DONE;
            WR_ISSUE: begin
                cnt_n   = cnt + CNT_W'(1);
                state_n = last ? WR_DONE : WR_ISSUE;
            end
            default:  state_n = IDLE;
        endcase
        if ((state == RD_ISSUE && cnt != '0) || state == RD_DRAIN)
            line_in_n[{wi, 5'b0} +: 32] = MEM_DOUT2;
        if (ADAPTERRESET) begin
            state_n   = IDLE;
            cnt_n     = '0;
            line_in_n = CACHELINEIN;
        end
        // outputs are registered from the next state so the pins line up with the state they belong to
        rden_n    = state_n == RD_ISSUE;
        we_n      = state_n == WR_ISSUE;
        ready_n   = state_n == RD_DONE;
        written_n = state_n == WR_DONE;
        addr_n    = (rden_n || we_n) ? {base_n, cnt_n, 2'b00} : '0;
        din_n     = we_n ? wline_n[{cnt_n, 5'b0} +: 32] : '0;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state            <= IDLE;
            cnt              <= '0;
            base             <= '0;
            wline            <= '0;
            CACHELINEIN      <= '0;
            CACHELINEREADY   <= 1'b0;
            CACHELINEWRITTEN <= 1'b0;
            MEM_RDEN2        <= 1'b0;
            MEM_WE2          <= 1'b0;
            MEM_ADDR2        <= '0;
            MEM_DIN2         <= '0;
        end else begin
            state            <= state_n;
            cnt              <= cnt_n;
            base             <= base_n;
            wline            <= wline_n;
            CACHELINEIN      <= line_in_n;
            CACHELINEREADY   <= ready_n;
            CACHELINEWRITTEN <= written_n;
            MEM_RDEN2        <= rden_n;
            MEM_WE2          <= we_n;
            MEM_ADDR2        <= addr_n;
            MEM_DIN2         <= din_n;
        end
    end
endmodule

// File: tb/tb_cache_line_adapter.sv
// tb_cache_line_adapter: directed, table-driven checks of cache_line_adapter against a word RAM model
module tb_cache_line_adapter;
    logic         CLK = 1'b0;
    logic         RESET_N = 1'b0;
    logic         ADAPTERRESET = 1'b0;
    logic         READ_MISS = 1'b0;
    logic [31:0]  READWRITE_MISS_ADDR = '0;
    logic         MEMORYWRITE = 1'b0;
    logic [31:0]  WRITEBACK_ADDR = '0;
    logic [255:0] CACHELINEOUT = '0;
    logic [255:0] CACHELINEIN;
    logic         CACHELINEREADY, CACHELINEWRITTEN, MEM_RDEN2, MEM_WE2;
    logic [31:0]  MEM_ADDR2, MEM_DIN2;
    logic [1:0]   MEM_SIZE2;
    logic [31:0]  MEM_DOUT2 = '0;

    int ncmp = 0;
    int nerr = 0;
    logic [31:0]  mem [256];
    bit           wrn [256];
    logic [31:0]  shadow [256];
    bit           swr [256];
    logic [255:0] last_line = '0;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] seed;
        logic [31:0] exp_base;
    } vec_t;
    vec_t vecs [9];

    cache_line_adapter dut (
        .CLK(CLK), .RESET_N(RESET_N), .ADAPTERRESET(ADAPTERRESET),
        .READ_MISS(READ_MISS), .READWRITE_MISS_ADDR(READWRITE_MISS_ADDR),
        .MEMORYWRITE(MEMORYWRITE), .WRITEBACK_ADDR(WRITEBACK_ADDR),
        .CACHELINEOUT(CACHELINEOUT), .CACHELINEIN(CACHELINEIN),
        .CACHELINEREADY(CACHELINEREADY), .CACHELINEWRITTEN(CACHELINEWRITTEN),
        .MEM_RDEN2(MEM_RDEN2), .MEM_WE2(MEM_WE2), .MEM_ADDR2(MEM_ADDR2),
        .MEM_SIZE2(MEM_SIZE2), .MEM_DIN2(MEM_DIN2), .MEM_DOUT2(MEM_DOUT2)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] init_val(input int i);
        return (i >= 80 && i < 88) ? 32'hA000_0000 + 32'(i - 80) : 32'hC0DE_0000 | 32'(i);
    endfunction

    always @(posedge CLK) begin
        if (MEM_WE2) begin
            mem[MEM_ADDR2[9:2]] <= MEM_DIN2;
            wrn[MEM_ADDR2[9:2]] <= 1'b1;
        end
        if (MEM_RDEN2)
            MEM_DOUT2 <= wrn[MEM_ADDR2[9:2]] ? mem[MEM_ADDR2[9:2]] : init_val(int'(MEM_ADDR2[9:2]));
    end

    always @(negedge CLK)
        if (MEM_RDEN2 && MEM_WE2) begin
            nerr++;
            $display("FAIL excl: RDEN2=%0b WE2=%0b both high, required not both", MEM_RDEN2, MEM_WE2);
        end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic chkl(input string nm, input logic [255:0] act, input logic [255:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [255:0] model_line(input logic [31:0] b);
        logic [255:0] l;
        logic [7:0]   idx;
        for (int k = 0; k < 8; k++) begin
            idx = b[9:2] + 8'(k);
            l[32*k +: 32] = swr[idx] ? shadow[idx] : init_val(int'(idx));
        end
        return l;
    endfunction

    // full transaction from request cycle T; returns in the cycle after the done pulse
    task automatic run_txn(input logic wr, input logic [31:0] a, input logic [31:0] eb,
                           input logic [31:0] seed, input string nm);
        logic [255:0] line, exp;
        logic [7:0]   idx;
        for (int k = 0; k < 8; k++) line[32*k +: 32] = seed + 32'(k);
        exp = model_line(eb);
        if (wr) begin
            MEMORYWRITE = 1'b1; WRITEBACK_ADDR = a; CACHELINEOUT = line;
        end else begin
            READ_MISS = 1'b1; READWRITE_MISS_ADDR = a;
        end
        step();
        if (!wr) chkl({nm, " hold"}, CACHELINEIN, last_line);
        for (int k = 0; k < 8; k++) begin
            chk({nm, " strobe"}, 32'(wr ? MEM_WE2 : MEM_RDEN2), 32'd1);
            chk({nm, " other"}, 32'(wr ? MEM_RDEN2 : MEM_WE2), 32'd0);
            chk({nm, " addr"}, MEM_ADDR2, eb + 32'(4 * k));
            if (wr) chk({nm, " din"}, MEM_DIN2, line[32*k +: 32]);
            chk({nm, " early done"}, 32'(CACHELINEREADY | CACHELINEWRITTEN), 32'd0);
            step();
        end
        if (wr) begin
            chk({nm, " written"}, 32'(CACHELINEWRITTEN), 32'd1);
            chk({nm, " we off"}, 32'(MEM_WE2), 32'd0);
            for (int k = 0; k < 8; k++) begin
                idx = eb[9:2] + 8'(k);
                shadow[idx] = line[32*k +: 32];
                swr[idx] = 1'b1;
            end
            MEMORYWRITE = 1'b0;
            step();
            chk({nm, " written pulse"}, 32'(CACHELINEWRITTEN), 32'd0);
        end else begin
            chk({nm, " drain rden"}, 32'(MEM_RDEN2), 32'd0);
            chk({nm, " ready early"}, 32'(CACHELINEREADY), 32'd0);
            step();
            chk({nm, " ready"}, 32'(CACHELINEREADY), 32'd1);
            chkl({nm, " line"}, CACHELINEIN, exp);
            last_line = exp;
            READ_MISS = 1'b0;
            step();
            chk({nm, " ready pulse"}, 32'(CACHELINEREADY), 32'd0);
            chkl({nm, " line held"}, CACHELINEIN, exp);
        end
        chk({nm, " idle"}, 32'(MEM_RDEN2 | MEM_WE2), 32'd0);
    endtask

    initial begin
        logic [255:0] partial;
        logic [255:0] fetched;
        vecs[0] = '{1'b0, 32'h0000_0147, 32'h0,         32'h0000_0140};
        vecs[1] = '{1'b1, 32'h0000_02A0, 32'h5000,      32'h0000_02A0};
        vecs[2] = '{1'b0, 32'h0000_02BF, 32'h0,         32'h0000_02A0};
        vecs[3] = '{1'b0, 32'h0000_0000, 32'h0,         32'h0000_0000};
        vecs[4] = '{1'b0, 32'h0000_0020, 32'h0,         32'h0000_0020};
        vecs[5] = '{1'b1, 32'hFFFF_FFFF, 32'hBEEF_0000, 32'hFFFF_FFE0};
        vecs[6] = '{1'b0, 32'h0000_03E4, 32'h0,         32'h0000_03E0};
        vecs[7] = '{1'b1, 32'h0000_001F, 32'h1234_0000, 32'h0000_0000};
        vecs[8] = '{1'b0, 32'h0000_0005, 32'h0,         32'h0000_0000};

        #1;
        chk("rst rden", 32'(MEM_RDEN2), 32'd0);
        chk("rst we", 32'(MEM_WE2), 32'd0);
        chk("rst ready", 32'(CACHELINEREADY), 32'd0);
        chk("rst written", 32'(CACHELINEWRITTEN), 32'd0);
        chk("rst addr", MEM_ADDR2, 32'd0);
        chk("rst din", MEM_DIN2, 32'd0);
        chk("size", 32'(MEM_SIZE2), 32'd2);
        chkl("rst line", CACHELINEIN, 256'd0);
        step();
        step();
        RESET_N = 1'b1;
        step();

        for (int v = 0; v < 9; v++)
            run_txn(vecs[v].wr, vecs[v].addr, vecs[v].exp_base, vecs[v].seed, $sformatf("vec%0d", v));

        // simultaneous requests: writeback first, read accepted in the idle cycle after WRITTEN
        READ_MISS = 1'b1; READWRITE_MISS_ADDR = 32'h100;
        MEMORYWRITE = 1'b1; WRITEBACK_ADDR = 32'h200;
        for (int k = 0; k < 8; k++) CACHELINEOUT[32*k +: 32] = 32'h6000 + 32'(k);
        step();
        for (int k = 0; k < 8; k++) begin
            chk("both we", 32'(MEM_WE2), 32'd1);
            chk("both rden", 32'(MEM_RDEN2), 32'd0);
            chk("both addr", MEM_ADDR2, 32'h200 + 32'(4 * k));
            step();
        end
        chk("both written", 32'(CACHELINEWRITTEN), 32'd1);
        for (int k = 0; k < 8; k++) begin
            shadow[8'h80 + 8'(k)] = 32'h6000 + 32'(k);
            swr[8'h80 + 8'(k)] = 1'b1;
        end
        MEMORYWRITE = 1'b0;
        step();
        chk("both gap", 32'(MEM_RDEN2 | MEM_WE2), 32'd0);
        run_txn(1'b0, 32'h100, 32'h100, 32'h0, "both rd");
        fetched = model_line(32'h200);
        chkl("both readback", fetched, {32'h6007, 32'h6006, 32'h6005, 32'h6004,
                                        32'h6003, 32'h6002, 32'h6001, 32'h6000});

        // abort a read in issue cycle 3: words 0 and 1 already captured, word 2 is not
        READ_MISS = 1'b1; READWRITE_MISS_ADDR = 32'h60;
        step();
        step();
        step();
        step();
        chk("abort pre addr", MEM_ADDR2, 32'h6C);
        ADAPTERRESET = 1'b1; READ_MISS = 1'b0;
        step();
        ADAPTERRESET = 1'b0;
        partial = last_line;
        partial[31:0]  = init_val(24);
        partial[63:32] = init_val(25);
        chkl("abort line", CACHELINEIN, partial);
        for (int c = 0; c < 12; c++) begin
            chk("abort rden", 32'(MEM_RDEN2), 32'd0);
            chk("abort ready", 32'(CACHELINEREADY), 32'd0);
            step();
        end
        last_line = partial;
        run_txn(1'b0, 32'hE0, 32'hE0, 32'h0, "post abort");

        // asynchronous reset in write issue cycle 5
        MEMORYWRITE = 1'b1; WRITEBACK_ADDR = 32'h180;
        for (int k = 0; k < 8; k++) CACHELINEOUT[32*k +: 32] = 32'h9000 + 32'(k);
        step();
        for (int k = 0; k < 5; k++) step();
        chk("arst pre we", 32'(MEM_WE2), 32'd1);
        chk("arst pre addr", MEM_ADDR2, 32'h194);
        #2;
        RESET_N = 1'b0; MEMORYWRITE = 1'b0;
        #1;
        chk("arst we", 32'(MEM_WE2), 32'd0);
        chk("arst addr", MEM_ADDR2, 32'd0);
        chk("arst din", MEM_DIN2, 32'd0);
        step();
        RESET_N = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            chk("arst written", 32'(CACHELINEWRITTEN), 32'd0);
            chk("arst strobes", 32'(MEM_WE2 | MEM_RDEN2 | CACHELINEREADY), 32'd0);
        end
        chk("arst addr idle", MEM_ADDR2, 32'd0);
        chkl("arst line", CACHELINEIN, 256'd0);
        last_line = '0;
        run_txn(1'b0, 32'h147, 32'h140, 32'h0, "post arst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
